// File: rtl/vga_dither_out.sv
`default_nettype none
// vga_dither_out: 24-bit clocked-video to 4-bit-per-channel VGA DAC stage with
// 4x4 ordered dither, sync re-polarisation, underflow blanking and statistics.
// Revision: 1.0
module vga_dither_out #(
  parameter bit HS_ACTIVE_LOW   = 1'b1,
  parameter bit VS_ACTIVE_LOW   = 1'b1,
  parameter bit UNDERFLOW_BLANK = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] vid_data,
  input  logic        vid_datavalid,
  input  logic        vid_h_sync,
  input  logic        vid_v_sync,
  input  logic        vid_underflow,
  input  logic        dither_en,
  input  logic        stat_clr,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [15:0] frame_count,
  output logic [7:0]  ufl_count,
  output logic        underflow_sticky
);

  localparam logic [1:0] ST_WAIT_VS  = 2'd0;
  localparam logic [1:0] ST_ACTIVE   = 2'd1;
  localparam logic [1:0] ST_BLANKED  = 2'd2;

  // Stage 1: input register plus previous-cycle copies for edge detection
  logic [23:0] s1_data_q;
  logic        s1_dv_q;
  logic        s1_hs_q;
  logic        s1_vs_q;
  logic        s1_ufl_q;
  logic        s1_de_q;
  logic        s1_clr_q;
  logic        p_vs_q;
  logic        p_ufl_q;
  logic [1:0]  x_q;
  logic [1:0]  x_d;
  logic [1:0]  y_q;
  logic [1:0]  y_d;

  // Stage 2: output register, state and statistics
  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic [11:0] rgb_q;
  logic [11:0] rgb_d;
  logic        hs_q;
  logic        hs_d;
  logic        vs_q;
  logic        vs_d;
  logic [15:0] frame_q;
  logic [15:0] frame_d;
  logic [7:0]  ufl_cnt_q;
  logic [7:0]  ufl_cnt_d;
  logic        sticky_q;
  logic        sticky_d;

  logic        w_vs_rise;
  logic        w_ufl_rise;
  logic        w_blank_ev;
  logic [3:0]  w_thr;
  logic [11:0] w_pix;

  function automatic logic [3:0] bayer_thr(input logic [1:0] y, input logic [1:0] x);
    logic [3:0] t;
    case ({y, x})
      4'h0: t = 4'd0;
      4'h1: t = 4'd8;
      4'h2: t = 4'd2;
      4'h3: t = 4'd10;
      4'h4: t = 4'd12;
      4'h5: t = 4'd4;
      4'h6: t = 4'd14;
      4'h7: t = 4'd6;
      4'h8: t = 4'd3;
      4'h9: t = 4'd11;
      4'hA: t = 4'd1;
      4'hB: t = 4'd9;
      4'hC: t = 4'd15;
      4'hD: t = 4'd7;
      4'hE: t = 4'd13;
      default: t = 4'd5;
    endcase
    return t;
  endfunction

  // A carry out of the 8-bit sum means the channel saturates at full scale.
  function automatic logic [3:0] dither_ch(input logic [7:0] c, input logic [3:0] t,
                                           input logic en);
    logic [8:0] s;
    s = {1'b0, c} + {5'd0, t};
    if (!en) begin
      return c[7:4];
    end
    return s[8] ? 4'hF : s[7:4];
  endfunction

  // x/y track the pixel being captured into stage 1 so they align with s1_data_q.
  always_comb begin
    x_d = 2'd0;
    if (vid_datavalid && s1_dv_q) begin
      x_d = x_q + 2'd1;
    end
    y_d = y_q;
    if (vid_v_sync && !s1_vs_q) begin
      y_d = 2'd0;
    end else if (s1_dv_q && !vid_datavalid) begin
      y_d = y_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_data_q <= 24'd0;
      s1_dv_q   <= 1'b0;
      s1_hs_q   <= 1'b0;
      s1_vs_q   <= 1'b0;
      s1_ufl_q  <= 1'b0;
      s1_de_q   <= 1'b0;
      s1_clr_q  <= 1'b0;
      p_vs_q    <= 1'b0;
      p_ufl_q   <= 1'b0;
      x_q       <= 2'd0;
      y_q       <= 2'd0;
    end else begin
      s1_data_q <= vid_data;
      s1_dv_q   <= vid_datavalid;
      s1_hs_q   <= vid_h_sync;
      s1_vs_q   <= vid_v_sync;
      s1_ufl_q  <= vid_underflow;
      s1_de_q   <= dither_en;
      s1_clr_q  <= stat_clr;
      p_vs_q    <= s1_vs_q;
      p_ufl_q   <= s1_ufl_q;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  assign w_vs_rise  = s1_vs_q & ~p_vs_q;
  assign w_ufl_rise = s1_ufl_q & ~p_ufl_q;
  assign w_blank_ev = w_ufl_rise & UNDERFLOW_BLANK;

  // Underflow beats a coincident v_sync rise, so the whole new frame is blanked.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT_VS: begin
        if (w_vs_rise) begin
          state_d = w_blank_ev ? ST_BLANKED : ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (w_blank_ev) begin
          state_d = ST_BLANKED;
        end
      end
      ST_BLANKED: begin
        if (w_vs_rise) begin
          state_d = w_blank_ev ? ST_BLANKED : ST_ACTIVE;
        end
      end
      default: state_d = ST_WAIT_VS;
    endcase
  end

  assign w_thr = bayer_thr(y_q, x_q);
  assign w_pix = {dither_ch(s1_data_q[23:16], w_thr, s1_de_q),
                  dither_ch(s1_data_q[15:8],  w_thr, s1_de_q),
                  dither_ch(s1_data_q[7:0],   w_thr, s1_de_q)};

  // Forcing uses the next state so state changes hit the triggering pixel itself.
  always_comb begin
    rgb_d = 12'h000;
    if (s1_dv_q && (state_d == ST_ACTIVE)) begin
      rgb_d = w_pix;
    end
    hs_d = s1_hs_q ^ HS_ACTIVE_LOW;
    vs_d = s1_vs_q ^ VS_ACTIVE_LOW;
  end

  always_comb begin
    frame_d = frame_q + {15'd0, w_vs_rise};
    if (s1_clr_q) begin
      sticky_d  = w_ufl_rise;
      ufl_cnt_d = {7'd0, w_ufl_rise};
    end else begin
      sticky_d  = sticky_q | w_ufl_rise;
      ufl_cnt_d = ufl_cnt_q;
      if (w_ufl_rise && (ufl_cnt_q != 8'hFF)) begin
        ufl_cnt_d = ufl_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_WAIT_VS;
      rgb_q     <= 12'h000;
      hs_q      <= HS_ACTIVE_LOW;
      vs_q      <= VS_ACTIVE_LOW;
      frame_q   <= 16'd0;
      ufl_cnt_q <= 8'd0;
      sticky_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rgb_q     <= rgb_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      frame_q   <= frame_d;
      ufl_cnt_q <= ufl_cnt_d;
      sticky_q  <= sticky_d;
    end
  end

  assign vga_r            = rgb_q[11:8];
  assign vga_g            = rgb_q[7:4];
  assign vga_b            = rgb_q[3:0];
  assign vga_hs           = hs_q;
  assign vga_vs           = vs_q;
  assign frame_count      = frame_q;
  assign ufl_count        = ufl_cnt_q;
  assign underflow_sticky = sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_dither_out.sv
`default_nettype none
// tb_vga_dither_out: drives two vga_dither_out instances (default and inverted
// parameters) and checks every output cycle against a frame-level reference model.
module tb_vga_dither_out;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [23:0] vid_data = 24'd0;
  logic        vid_datavalid = 1'b0;
  logic        vid_h_sync = 1'b0;
  logic        vid_v_sync = 1'b0;
  logic        vid_underflow = 1'b0;
  logic        dither_en = 1'b0;
  logic        stat_clr = 1'b0;

  logic [3:0]  r0, g0, b0, r1, g1, b1;
  logic        hs0, vs0, hs1, vs1, st0, st1;
  logic [15:0] fc0, fc1;
  logic [7:0]  uc0, uc1;

  vga_dither_out u_dut (
    .clk(clk), .reset_n(reset_n), .vid_data(vid_data), .vid_datavalid(vid_datavalid),
    .vid_h_sync(vid_h_sync), .vid_v_sync(vid_v_sync), .vid_underflow(vid_underflow),
    .dither_en(dither_en), .stat_clr(stat_clr),
    .vga_r(r0), .vga_g(g0), .vga_b(b0), .vga_hs(hs0), .vga_vs(vs0),
    .frame_count(fc0), .ufl_count(uc0), .underflow_sticky(st0)
  );

  vga_dither_out #(
    .HS_ACTIVE_LOW(1'b0), .VS_ACTIVE_LOW(1'b0), .UNDERFLOW_BLANK(1'b0)
  ) u_alt (
    .clk(clk), .reset_n(reset_n), .vid_data(vid_data), .vid_datavalid(vid_datavalid),
    .vid_h_sync(vid_h_sync), .vid_v_sync(vid_v_sync), .vid_underflow(vid_underflow),
    .dither_en(dither_en), .stat_clr(stat_clr),
    .vga_r(r1), .vga_g(g1), .vga_b(b1), .vga_hs(hs1), .vga_vs(vs1),
    .frame_count(fc1), .ufl_count(uc1), .underflow_sticky(st1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] d;
    logic dv; logic hs; logic vs; logic ufl; logic clr; logic de;
  } stim_t;

  localparam logic [77:0] RST_EXP = {12'h000, 2'b11, 12'h000, 2'b00, 25'd0, 25'd0};

  stim_t       sq[$];
  logic        g_de;
  int          n_vec, n_err;
  logic [77:0] e_cur, e_pend, w_all;

  assign w_all = {r0, g0, b0, hs0, vs0, r1, g1, b1, hs1, vs1, fc0, uc0, st0, fc1, uc1, st1};

  // Reference model state: frame-level flags and positions
  int          bayer [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};
  bit          m_wait, m_blank, m_pvs, m_pufl, m_pdv, m_sticky;
  int          m_col, m_row, m_ufl;
  logic [15:0] m_frames;

  function automatic logic [3:0] chan(input logic [7:0] c, input int t, input logic de);
    int v;
    if (!de) return c[7:4];
    v = (int'(c) + t) / 16;
    if (v > 15) v = 15;
    return 4'(v);
  endfunction

  task automatic model_reset();
    m_wait = 1; m_blank = 0; m_pvs = 0; m_pufl = 0; m_pdv = 0; m_sticky = 0;
    m_col = 0; m_row = 0; m_ufl = 0; m_frames = 16'd0;
  endtask

  task automatic model_step(input stim_t s, output logic [77:0] e);
    bit vr, ur;
    int t;
    logic [11:0] px;
    logic [13:0] o0, o1;
    logic [24:0] st;
    vr = s.vs && !m_pvs;
    ur = s.ufl && !m_pufl;
    if (vr) m_row = 0;
    else if (m_pdv && !s.dv) m_row = (m_row + 1) % 4;
    if (s.dv) m_col = m_pdv ? (m_col + 1) % 4 : 0;
    if (m_wait) begin
      if (vr) begin m_wait = 0; m_blank = ur; end
    end else if (m_blank) begin
      if (vr) m_blank = ur;
    end else if (ur) begin
      m_blank = 1;
    end
    t  = bayer[m_row][m_col];
    px = {chan(s.d[23:16], t, s.de), chan(s.d[15:8], t, s.de), chan(s.d[7:0], t, s.de)};
    o0 = {(s.dv && !m_wait && !m_blank) ? px : 12'h000, !s.hs, !s.vs};
    o1 = {(s.dv && !m_wait) ? px : 12'h000, s.hs, s.vs};
    if (vr) m_frames = m_frames + 16'd1;
    if (s.clr) begin
      m_ufl = ur ? 1 : 0; m_sticky = ur;
    end else if (ur) begin
      m_ufl = (m_ufl < 255) ? m_ufl + 1 : 255; m_sticky = 1;
    end
    st = {m_frames, 8'(m_ufl), m_sticky};
    e  = {o0, o1, st, st};
    m_pvs = s.vs; m_pufl = s.ufl; m_pdv = s.dv;
  endtask

  task automatic cycle(input stim_t s);
    logic [77:0] e_new;
    vid_data = s.d; vid_datavalid = s.dv; vid_h_sync = s.hs; vid_v_sync = s.vs;
    vid_underflow = s.ufl; stat_clr = s.clr; dither_en = s.de;
    model_step(s, e_new);
    @(posedge clk); #1;
    e_cur  = e_pend;
    e_pend = e_new;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    model_reset();
    e_cur = RST_EXP; e_pend = RST_EXP;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Stimulus builders
  task automatic push(input logic [23:0] d, input logic dv, hs, vs, ufl, clr);
    stim_t s;
    s.d = d; s.dv = dv; s.hs = hs; s.vs = vs; s.ufl = ufl; s.clr = clr; s.de = g_de;
    sq.push_back(s);
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) push(24'h0, 0, 0, 0, 0, 0);
  endtask

  task automatic add_vsync(input logic ufl);
    push(24'h0, 0, 0, 1, ufl, 0);
    push(24'h0, 0, 0, 1, 0, 0);
    push(24'h0, 0, 0, 0, 0, 0);
  endtask

  task automatic add_line(input int np, input bit fixed, input logic [23:0] val, input int ufl_pix);
    push(24'h0, 0, 1, 0, 0, 0);
    add_idle(2);
    for (int i = 0; i < np; i++) push(fixed ? val : 24'($urandom), 1, 0, 0, i == ufl_pix, 0);
    add_idle(2);
  endtask

  task automatic add_frame(input int nl, input int np, input bit fixed, input logic [23:0] val,
                           input int ufl_line, input int ufl_pix, input logic vs_ufl);
    add_vsync(vs_ufl);
    add_idle(2);
    for (int l = 0; l < nl; l++) add_line(np, fixed, val, (l == ufl_line) ? ufl_pix : -1);
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if (w_all !== RST_EXP) begin
      n_err++; $display("FAIL reset_state: dut %h, required %h", w_all, RST_EXP);
    end
  endtask

  task automatic test_first_frame();
    stim_t s;
    int nz;
    g_de = 1; nz = 0;
    for (int i = 0; i < 6; i++) push(24'hFFFFFF, 1, 0, 0, 0, 0);
    add_idle(2);
    while (sq.size() > 0) begin
      s = sq.pop_front(); cycle(s); n_vec++;
      if (w_all !== e_cur) begin n_err++; $display("FAIL first_prevs: dut %h, model %h", w_all, e_cur); end
      if ({r0, g0, b0} != 12'h000) nz++;
    end
    n_vec++;
    if (nz != 0) begin n_err++; $display("FAIL first_black: %0d lit cycles, required 0", nz); end
    add_frame(2, 6, 1, 24'hFFFFFF, -1, -1, 0);
    push(24'hFFFFFF, 1, 0, 0, 0, 0);
    add_idle(1);
    while (sq.size() > 0) begin
      s = sq.pop_front(); cycle(s); n_vec++;
      if (w_all !== e_cur) begin n_err++; $display("FAIL first_frame: dut %h, model %h", w_all, e_cur); end
    end
    n_vec++;
    if ({r0, g0, b0} !== 12'hFFF || fc0 !== 16'd1) begin
      n_err++; $display("FAIL first_white: rgb %h fc %0d, required fff fc 1", {r0, g0, b0}, fc0);
    end
  endtask

  task automatic test_dither();
    stim_t s;
    int n8, n9;
    for (int de = 1; de >= 0; de--) begin
      g_de = 1'(de); n8 = 0; n9 = 0;
      add_frame(4, 4, 1, 24'h888888, -1, -1, 0);
      add_idle(1);
      while (sq.size() > 0) begin
        s = sq.pop_front(); cycle(s); n_vec++;
        if (w_all !== e_cur) begin n_err++; $display("FAIL dither de%0d: dut %h, model %h", de, w_all, e_cur); end
        if (r0 == 4'd8 && g0 == 4'd8 && b0 == 4'd8) n8++;
        if (r0 == 4'd9 && g0 == 4'd9 && b0 == 4'd9) n9++;
      end
      n_vec++;
      if ((de == 1 && (n8 != 8 || n9 != 8)) || (de == 0 && (n8 != 16 || n9 != 0))) begin
        n_err++; $display("FAIL dither_count de%0d: n8 %0d n9 %0d", de, n8, n9);
      end
    end
  endtask

  task automatic test_saturation();
    stim_t s;
    int nsat;
    g_de = 1; nsat = 0;
    add_vsync(0); add_idle(2);
    for (int l = 0; l < 4; l++) begin
      push(24'h0, 0, 1, 0, 0, 0); add_idle(2);
      for (int p = 0; p < 4; p++) push((l == 3 && p == 0) ? 24'hFF00FF : 24'($urandom), 1, 0, 0, 0, 0);
      add_idle(2);
    end
    while (sq.size() > 0) begin
      s = sq.pop_front(); cycle(s); n_vec++;
      if (w_all !== e_cur) begin n_err++; $display("FAIL saturation: dut %h, model %h", w_all, e_cur); end
      if ({r0, g0, b0} == 12'hF0F) nsat++;
    end
    n_vec++;
    if (nsat == 0) begin n_err++; $display("FAIL sat_pixel: f0f seen %0d times, required >=1", nsat); end
  endtask

  task automatic test_sync();
    stim_t s;
    int nlow, nhigh, klow;
    nlow = 0; nhigh = 0; klow = -1;
    add_idle(3); push(24'h0, 0, 1, 0, 0, 0); add_idle(4);
    for (int k = 0; sq.size() > 0; k++) begin
      s = sq.pop_front(); cycle(s); n_vec++;
      if (w_all !== e_cur) begin n_err++; $display("FAIL sync: dut %h, model %h", w_all, e_cur); end
      if (hs0 == 1'b0) begin nlow++; klow = k; end
      if (hs1 == 1'b1) nhigh++;
    end
    n_vec++;
    if (nlow != 1 || klow != 4 || nhigh != 1) begin
      n_err++; $display("FAIL hs_pulse: low %0d at %0d, alt high %0d, required 1 at 4, 1", nlow, klow, nhigh);
    end
  endtask

  task automatic test_underflow();
    stim_t s;
    apply_reset();
    g_de = 1;
    add_frame(2, 8, 0, 24'h0, -1, -1, 0);
    add_frame(12, 8, 0, 24'h0, 10, 4, 0);
    add_frame(2, 8, 0, 24'h0, -1, -1, 0);
    add_idle(2);
    while (sq.size() > 0) begin
      s = sq.pop_front(); cycle(s); n_vec++;
      if (w_all !== e_cur) begin n_err++; $display("FAIL underflow: dut %h, model %h", w_all, e_cur); end
    end
    n_vec++;
    if (uc0 !== 8'd1 || st0 !== 1'b1 || uc1 !== 8'd1 || st1 !== 1'b1 || fc0 !== 16'd3) begin
      n_err++; $display("FAIL ufl_stats: uc %0d/%0d sticky %b/%b fc %0d, required 1 1 fc 3", uc0, uc1, st0, st1, fc0);
    end
  endtask

  task automatic test_simultaneous();
    stim_t s;
    int nz0, nz1;
    nz0 = 0; nz1 = 0; g_de = 1;
    add_frame(3, 6, 1, 24'h808080, -1, -1, 1);
    add_idle(1);
    while (sq.size() > 0) begin
      s = sq.pop_front(); cycle(s); n_vec++;
      if (w_all !== e_cur) begin n_err++; $display("FAIL simul_vs: dut %h, model %h", w_all, e_cur); end
      if ({r0, g0, b0} != 12'h000) nz0++;
      if ({r1, g1, b1} != 12'h000) nz1++;
    end
    n_vec++;
    if (nz0 != 0 || nz1 != 18) begin n_err++; $display("FAIL simul_blank: lit %0d/%0d, required 0/18", nz0, nz1); end
    for (int i = 0; i < 3; i++) begin push(24'h0, 0, 0, 0, 1, 0); push(24'h0, 0, 0, 0, 0, 0); end
    push(24'h0, 0, 0, 0, 1, 1);
    add_idle(3);
    while (sq.size() > 0) begin
      s = sq.pop_front(); cycle(s); n_vec++;
      if (w_all !== e_cur) begin n_err++; $display("FAIL simul_clr: dut %h, model %h", w_all, e_cur); end
    end
    n_vec++;
    if (uc0 !== 8'd1 || st0 !== 1'b1 || uc1 !== 8'd1) begin
      n_err++; $display("FAIL clr_and_ufl: uc %0d sticky %b, required 1 1", uc0, st0);
    end
    for (int i = 0; i < 300; i++) begin push(24'h0, 0, 0, 0, 1, 0); push(24'h0, 0, 0, 0, 0, 0); end
    add_idle(2);
    while (sq.size() > 0) begin
      s = sq.pop_front(); cycle(s); n_vec++;
      if (w_all !== e_cur) begin n_err++; $display("FAIL ufl_sat: dut %h, model %h", w_all, e_cur); end
    end
    n_vec++;
    if (uc0 !== 8'd255 || st0 !== 1'b1) begin
      n_err++; $display("FAIL ufl_255: uc %0d sticky %b, required 255 1", uc0, st0);
    end
  endtask

  task automatic test_random();
    stim_t s;
    int nl, np, half;
    for (int f = 0; f < 8; f++) begin
      g_de = 1'($urandom);
      nl = 2 + int'($urandom_range(0, 3));
      np = 3 + int'($urandom_range(0, 6));
      add_frame(nl, np, 0, 24'h0, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, nl - 1)) : -1,
                int'($urandom_range(0, np - 1)), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) push(24'h0, 0, 0, 0, 0, 1);
      half = sq.size() / 2;
      for (int k = 0; sq.size() > 0; k++) begin
        if (f == 4 && k == half) apply_reset();
        s = sq.pop_front(); cycle(s); n_vec++;
        if (w_all !== e_cur) begin n_err++; $display("FAIL random f%0d: dut %h, model %h", f, w_all, e_cur); end
      end
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; g_de = 1;
    model_reset();
    e_cur = RST_EXP; e_pend = RST_EXP;
    test_reset();
    test_first_frame();
    test_dither();
    test_saturation();
    test_sync();
    test_underflow();
    test_simultaneous();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
